// File: rtl/anim_frame_sequencer.sv
// rtl/anim_frame_sequencer.sv - per-animation frame index sequencer with programmable rate
module anim_frame_sequencer #(
    parameter int ANI_W         = 6,
    parameter int FRAME_W       = 6,
    parameter int PRESCALE_W    = 24,
    parameter int DEFAULT_LIMIT = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  anim_load,
    input  logic [ANI_W-1:0]      animation,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] speed,
    output logic [ANI_W-1:0]      active_ani,
    output logic [FRAME_W-1:0]    limit,
    output logic [FRAME_W-1:0]    frame,
    output logic                  frame_tick,
    output logic                  wrap,
    output logic                  done
);

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    mode_t                 mode_q;
    logic                  dir_down;
    logic [PRESCALE_W-1:0] prescaler;
    logic [FRAME_W-1:0]    frame_inc;
    logic [FRAME_W-1:0]    frame_dec;
    logic                  step_due;

    // Last frame index for each animation; unlisted indices share the default
    function automatic int limit_lookup(input int idx);
        int lim;
        lim = DEFAULT_LIMIT;
        case (idx) inside
            0:        lim = 9;
            1:        lim = 11;
            [2:6]:    lim = 5;
            7:        lim = 1;
            [8:9]:    lim = 3;
            [10:14]:  lim = 1;
            15:       lim = 3;
            16:       lim = 4;
            17:       lim = 1;
            [18:22]:  lim = 6;
            23:       lim = 3;
            [24:27]:  lim = 15;
            28:       lim = 31;
            29:       lim = 3;
            30:       lim = 10;
            31:       lim = 31;
            32:       lim = 4;
            33:       lim = 8;
            [34:35]:  lim = 4;
            default:  lim = DEFAULT_LIMIT;
        endcase
        return lim;
    endfunction

    // Limit follows the latched animation combinationally
    always_comb begin
        limit = FRAME_W'(limit_lookup(int'(active_ani)));
    end

    assign frame_inc = frame + FRAME_W'(1);
    assign frame_dec = frame - FRAME_W'(1);
    // prescaler never exceeds speed except after speed is lowered, so >= catches both cases
    assign step_due  = (prescaler >= speed);

    // Sequencer state: load/restart, prescaler and frame stepping with registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            active_ani <= '0;
            mode_q     <= MODE_LOOP;
            frame      <= '0;
            dir_down   <= 1'b0;
            prescaler  <= '0;
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
        end else if (anim_load) begin
            active_ani <= animation;
            mode_q     <= mode_t'(mode);
            frame      <= '0;
            dir_down   <= 1'b0;
            prescaler  <= '0;
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            done       <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            if (enable) begin
                if (!step_due) begin
                    prescaler <= prescaler + PRESCALE_W'(1);
                end else begin
                    prescaler <= '0;
                    if (mode_q != MODE_HOLD && limit == '0) begin
                        // single-frame animation: every step completes a cycle
                        if (!(mode_q == MODE_ONESHOT && done)) begin
                            frame      <= '0;
                            frame_tick <= 1'b1;
                            wrap       <= 1'b1;
                            if (mode_q == MODE_ONESHOT) begin
                                done <= 1'b1;
                            end
                        end
                    end else begin
                        case (mode_q)
                            MODE_LOOP: begin
                                frame_tick <= 1'b1;
                                if (frame < limit) begin
                                    frame <= frame_inc;
                                end else begin
                                    frame <= '0;
                                    wrap  <= 1'b1;
                                end
                            end
                            MODE_PINGPONG: begin
                                frame_tick <= 1'b1;
                                if (!dir_down) begin
                                    if (frame < limit) begin
                                        frame <= frame_inc;
                                        if (frame_inc == limit) begin
                                            dir_down <= 1'b1;
                                        end
                                    end else begin
                                        frame    <= frame_dec;
                                        dir_down <= 1'b1;
                                    end
                                end else if (frame != '0) begin
                                    frame <= frame_dec;
                                    if (frame_dec == '0) begin
                                        wrap     <= 1'b1;
                                        dir_down <= 1'b0;
                                    end
                                end else begin
                                    dir_down <= 1'b0;
                                end
                            end
                            MODE_ONESHOT: begin
                                if (!done) begin
                                    frame_tick <= 1'b1;
                                    if (frame < limit) begin
                                        frame <= frame_inc;
                                        if (frame_inc == limit) begin
                                            done <= 1'b1;
                                            wrap <= 1'b1;
                                        end
                                    end else begin
                                        done <= 1'b1;
                                        wrap <= 1'b1;
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// tb/tb_anim_frame_sequencer.sv - self-checking bench for anim_frame_sequencer
module tb_anim_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        anim_load = 1'b0;
    logic [5:0]  animation = '0;
    logic [1:0]  mode = '0;
    logic [23:0] speed = '0;
    logic [5:0]  active_ani;
    logic [5:0]  limit;
    logic [5:0]  frame;
    logic        frame_tick;
    logic        wrap;
    logic        done;

    int tests = 0;
    int failed = 0;

    anim_frame_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .anim_load  (anim_load),
        .animation  (animation),
        .mode       (mode),
        .speed      (speed),
        .active_ani (active_ani),
        .limit      (limit),
        .frame      (frame),
        .frame_tick (frame_tick),
        .wrap       (wrap),
        .done       (done)
    );

    always #5 clk = ~clk;

    int lim_tab [36] = '{9, 11, 5, 5, 5, 5, 5, 1, 3, 3, 1, 1, 1, 1, 1, 3, 4, 1,
                         6, 6, 6, 6, 6, 3, 15, 15, 15, 15, 31, 3, 10, 31, 4, 8, 4, 4};

    function automatic int lim_of(input int a);
        return (a <= 35) ? lim_tab[a] : 63;
    endfunction

    int m_ani, m_mode, m_frame, m_pre;
    bit m_up, m_tick, m_wrap, m_done;
    logic [20:0] exp_q [$];

    task automatic model_clock(input bit rst, input bit ld, input bit en,
                               input int ani, input int md, input int spd);
        int lim;
        if (rst) begin
            m_ani = 0; m_mode = 0; m_frame = 0; m_up = 1; m_pre = 0;
            m_tick = 0; m_wrap = 0; m_done = 0;
        end else if (ld) begin
            m_ani = ani; m_mode = md; m_frame = 0; m_up = 1; m_pre = 0;
            m_tick = 0; m_wrap = 0; m_done = 0;
        end else begin
            m_tick = 0;
            m_wrap = 0;
            if (en) begin
                if (m_pre < spd) begin
                    m_pre++;
                end else begin
                    m_pre = 0;
                    lim = lim_of(m_ani);
                    case (m_mode)
                        0: begin
                            m_tick = 1;
                            if (m_frame < lim) m_frame++;
                            else begin m_frame = 0; m_wrap = 1; end
                        end
                        1: begin
                            m_tick = 1;
                            if (lim == 0) m_wrap = 1;
                            else if (m_up) begin
                                m_frame++;
                                if (m_frame == lim) m_up = 0;
                            end else begin
                                m_frame--;
                                if (m_frame == 0) begin m_wrap = 1; m_up = 1; end
                            end
                        end
                        2: begin
                            if (!m_done) begin
                                m_tick = 1;
                                if (m_frame < lim) m_frame++;
                                if (m_frame >= lim) begin m_done = 1; m_wrap = 1; end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    // One clock: drive at negedge, push model expectation, compare after the edge
    task automatic cyc(input bit rst, input bit ld, input bit en,
                       input logic [5:0] ani, input logic [1:0] md, input logic [23:0] spd);
        logic [20:0] got, e;
        @(negedge clk);
        reset = rst; anim_load = ld; enable = en; animation = ani; mode = md; speed = spd;
        model_clock(rst, ld, en, int'(ani), int'(md), int'(spd));
        exp_q.push_back({6'(m_ani), 6'(lim_of(m_ani)), 6'(m_frame), m_tick, m_wrap, m_done});
        @(posedge clk);
        #1;
        got = {active_ani, limit, frame, frame_tick, wrap, done};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            failed++;
            $display("FAIL cycle_model t=%0t got ani=%0d lim=%0d frame=%0d tick=%b wrap=%b done=%b expected ani=%0d lim=%0d frame=%0d tick=%b wrap=%b done=%b",
                     $time, got[20:15], got[14:9], got[8:3], got[2], got[1], got[0],
                     e[20:15], e[14:9], e[8:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  ani;
        logic [1:0]  md;
        logic [23:0] spd;
        logic        en;
        int          n;
        logic [5:0]  e_frame;
        logic [5:0]  e_lim;
        logic        e_wrap;
        logic        e_done;
    } vec_t;

    vec_t vt [12];

    initial begin
        int cnt;
        vt[0]  = '{6'd0,  2'd0, 24'd0, 1'b1, 9,  6'd9,  6'd9,  1'b0, 1'b0};
        vt[1]  = '{6'd0,  2'd0, 24'd0, 1'b1, 10, 6'd0,  6'd9,  1'b1, 1'b0};
        vt[2]  = '{6'd7,  2'd1, 24'd0, 1'b1, 2,  6'd0,  6'd1,  1'b1, 1'b0};
        vt[3]  = '{6'd7,  2'd1, 24'd0, 1'b1, 3,  6'd1,  6'd1,  1'b0, 1'b0};
        vt[4]  = '{6'd16, 2'd2, 24'd2, 1'b1, 12, 6'd4,  6'd4,  1'b1, 1'b1};
        vt[5]  = '{6'd16, 2'd2, 24'd2, 1'b1, 32, 6'd4,  6'd4,  1'b0, 1'b1};
        vt[6]  = '{6'd40, 2'd0, 24'd0, 1'b1, 0,  6'd0,  6'd63, 1'b0, 1'b0};
        vt[7]  = '{6'd10, 2'd3, 24'd0, 1'b1, 5,  6'd0,  6'd1,  1'b0, 1'b0};
        vt[8]  = '{6'd17, 2'd2, 24'd0, 1'b1, 1,  6'd1,  6'd1,  1'b1, 1'b1};
        vt[9]  = '{6'd63, 2'd0, 24'd0, 1'b1, 64, 6'd0,  6'd63, 1'b1, 1'b0};
        vt[10] = '{6'd2,  2'd1, 24'd1, 1'b1, 20, 6'd0,  6'd5,  1'b1, 1'b0};
        vt[11] = '{6'd2,  2'd1, 24'd0, 1'b0, 5,  6'd0,  6'd5,  1'b0, 1'b0};

        // reset state
        cyc(1, 0, 0, 6'd0, 2'd0, 24'd0);
        chk("reset_limit", 32'(limit), 9);
        chk("reset_frame", 32'(frame), 0);
        chk("reset_pulses", {29'd0, frame_tick, wrap, done}, 0);

        // table-driven scenarios: load, then run n cycles
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, vt[i].en, vt[i].ani, vt[i].md, vt[i].spd);
            for (int k = 0; k < vt[i].n; k++)
                cyc(0, 0, vt[i].en, vt[i].ani, vt[i].md, vt[i].spd);
            chk($sformatf("vec%0d_frame", i), 32'(frame), 32'(vt[i].e_frame));
            chk($sformatf("vec%0d_limit", i), 32'(limit), 32'(vt[i].e_lim));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vt[i].e_wrap));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
        end

        // anim_load overrides a due step
        cyc(0, 1, 1, 6'd28, 2'd0, 24'd0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 1, 6'd28, 2'd0, 24'd0);
        chk("ani28_frame20", 32'(frame), 20);
        cyc(0, 1, 1, 6'd1, 2'd0, 24'd0);
        chk("reload_frame", 32'(frame), 0);
        chk("reload_limit", 32'(limit), 11);
        chk("reload_tick", 32'(frame_tick), 0);
        chk("reload_done", 32'(done), 0);

        // enable freeze mid-count, then resume from held prescaler
        cyc(0, 1, 1, 6'd0, 2'd0, 24'd4);
        for (int k = 0; k < 17; k++) cyc(0, 0, 1, 6'd0, 2'd0, 24'd4);
        chk("pre_freeze_frame", 32'(frame), 3);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 6'd0, 2'd0, 24'd4);
        chk("frozen_frame", 32'(frame), 3);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 6'd0, 2'd0, 24'd4);
            cnt++;
            if (frame_tick) break;
        end
        chk("resume_latency", 32'(cnt), 3);
        chk("resume_frame", 32'(frame), 4);

        // lowering speed below the running count steps on the next cycle
        cyc(0, 1, 1, 6'd0, 2'd0, 24'd10);
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 6'd0, 2'd0, 24'd10);
        cyc(0, 0, 1, 6'd0, 2'd0, 24'd2);
        chk("speed_drop_tick", 32'(frame_tick), 1);
        chk("speed_drop_frame", 32'(frame), 1);

        // reset mid-run clears a sticky done
        cyc(0, 1, 1, 6'd17, 2'd2, 24'd0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 6'd17, 2'd2, 24'd0);
        chk("pre_reset_done", 32'(done), 1);
        cyc(1, 1, 1, 6'd33, 2'd1, 24'd0);
        chk("midrun_reset_ani", 32'(active_ani), 0);
        chk("midrun_reset_limit", 32'(limit), 9);
        chk("midrun_reset_state", {26'd0, frame, frame_tick, wrap, done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
